hazard_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage pipeline. It compares decode-stage source requirements (Tuse) against in-flight destination readiness (Tnew) held in the ID/EX and EX/MEM registers. From that it drives the PC/IF-ID hold, the ID/EX bubble insertion and the forwarding-mux selects. It also owns the multi-cycle multiply/divide busy sequencer and a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: Tuse/Tnew stall detection, forwarding selects,
// multiply/divide busy sequencer and stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_addr_D,
  input  logic [4:0]       rt_addr_D,
  input  logic [3:0]       rs_use_D,
  input  logic [3:0]       rt_use_D,
  input  logic             md_use_D,
  input  logic [4:0]       dst_addr_E,
  input  logic [3:0]       dst_save_E,
  input  logic [4:0]       dst_addr_M,
  input  logic [3:0]       dst_save_M,
  input  logic [4:0]       dst_addr_W,
  input  logic             md_start_E,
  input  logic             md_is_div_E,
  output logic             stall,
  output logic             pc_enable,
  output logic             fd_enable,
  output logic             de_flush,
  output logic [1:0]       fwd_rs_D,
  output logic [1:0]       fwd_rt_D,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] NO_USE = 4'd4;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]    lat_m1;
  logic             stall_rs, stall_rt, stall_md;

  function automatic logic data_stall(
    input logic [4:0] a,
    input logic [3:0] u,
    input logic [4:0] ae,
    input logic [3:0] te,
    input logic [4:0] am,
    input logic [3:0] tm
  );
    logic me, mm;
    me = (a != 5'd0) && (a == ae);
    mm = (a != 5'd0) && (a == am);
    return (u != NO_USE) && ((me && (u < te)) || (mm && (u < tm)));
  endfunction

  // Youngest producer wins; a not-ready younger producer hides older ones.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] a,
    input logic [4:0] ae,
    input logic [3:0] te,
    input logic [4:0] am,
    input logic [3:0] tm,
    input logic [4:0] aw
  );
    logic [1:0] s;
    s = 2'd0;
    if (a != 5'd0) begin
      if (a == ae)      s = (te == 4'd0) ? 2'd1 : 2'd0;
      else if (a == am) s = (tm == 4'd0) ? 2'd2 : 2'd0;
      else if (a == aw) s = 2'd3;
    end
    return s;
  endfunction

  assign stall_rs = data_stall(rs_addr_D, rs_use_D, dst_addr_E,
                               dst_save_E, dst_addr_M, dst_save_M);
  assign stall_rt = data_stall(rt_addr_D, rt_use_D, dst_addr_E,
                               dst_save_E, dst_addr_M, dst_save_M);
  assign stall_md = md_use_D && (md_busy || md_start_E);

  assign stall     = stall_rs | stall_rt | stall_md;
  assign pc_enable = !stall;
  assign fd_enable = !stall;
  assign de_flush  = stall;

  assign fwd_rs_D = fwd_sel(rs_addr_D, dst_addr_E, dst_save_E,
                            dst_addr_M, dst_save_M, dst_addr_W);
  assign fwd_rt_D = fwd_sel(rt_addr_D, dst_addr_E, dst_save_E,
                            dst_addr_M, dst_save_M, dst_addr_W);

  assign md_busy   = (state_q == S_BUSY);
  assign md_done   = md_busy && (cnt_q == CW'(1));
  assign stall_cnt = stall_cnt_q;

  assign lat_m1 = md_is_div_E ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (md_start_E && (lat_m1 != '0)) begin
          state_d = S_BUSY;
          cnt_d   = lat_m1;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed plan steps plus random
// cycles against a cycle-indexed reference model.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs_addr_D, rt_addr_D;
  logic [3:0]       rs_use_D, rt_use_D;
  logic             md_use_D;
  logic [4:0]       dst_addr_E, dst_addr_M, dst_addr_W;
  logic [3:0]       dst_save_E, dst_save_M;
  logic             md_start_E, md_is_div_E;
  logic             stall, pc_enable, fd_enable, de_flush;
  logic [1:0]       fwd_rs_D, fwd_rt_D;
  logic             md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model: absolute cycle index and the window of MDU busy cycles.
  longint    cyc;
  longint    bs, be;
  longint    m_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
    .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
    .md_use_D(md_use_D),
    .dst_addr_E(dst_addr_E), .dst_save_E(dst_save_E),
    .dst_addr_M(dst_addr_M), .dst_save_M(dst_save_M),
    .dst_addr_W(dst_addr_W),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
    .stall(stall), .pc_enable(pc_enable), .fd_enable(fd_enable),
    .de_flush(de_flush),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return (bs >= 0) && (cyc >= bs) && (cyc <= be);
  endfunction

  function automatic bit m_rstall(input int a, input int u);
    bit me, mm;
    if (u == 4) return 1'b0;
    me = (a != 0) && (a == int'(dst_addr_E));
    mm = (a != 0) && (a == int'(dst_addr_M));
    return (me && u < int'(dst_save_E)) || (mm && u < int'(dst_save_M));
  endfunction

  function automatic int m_fwd(input int a);
    if (a == 0) return 0;
    if (a == int'(dst_addr_E)) return (dst_save_E == 0) ? 1 : 0;
    if (a == int'(dst_addr_M)) return (dst_save_M == 0) ? 2 : 0;
    if (a == int'(dst_addr_W)) return 3;
    return 0;
  endfunction

  function automatic bit m_stall();
    return m_rstall(int'(rs_addr_D), int'(rs_use_D))
        || m_rstall(int'(rt_addr_D), int'(rt_use_D))
        || (md_use_D && (m_busy() || md_start_E));
  endfunction

  // Check all outputs for the current cycle, then clock and advance model.
  task automatic step();
    bit st;
    int lat;
    #1;
    st = m_stall();
    chk("stall", stall, st);
    chk("pc_enable", pc_enable, !st);
    chk("fd_enable", fd_enable, !st);
    chk("de_flush", de_flush, st);
    chk("fwd_rs", fwd_rs_D, m_fwd(int'(rs_addr_D)));
    chk("fwd_rt", fwd_rt_D, m_fwd(int'(rt_addr_D)));
    chk("md_busy", md_busy, m_busy());
    chk("md_done", md_done, m_busy() && cyc == be);
    chk("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    if (reset) begin
      bs = -1; be = -1; m_cnt = 0;
    end else begin
      if (st) m_cnt = (m_cnt + 1) % (longint'(1) << CNT_W);
      lat = md_is_div_E ? DIV_LAT : MULT_LAT;
      if (md_start_E && !m_busy() && lat > 1) begin
        bs = cyc + 1;
        be = cyc + lat - 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_in();
    rs_addr_D = 0; rt_addr_D = 0; rs_use_D = 4; rt_use_D = 4;
    md_use_D = 0; dst_addr_E = 0; dst_save_E = 0;
    dst_addr_M = 0; dst_save_M = 0; dst_addr_W = 0;
    md_start_E = 0; md_is_div_E = 0;
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    idle_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0; bs = -1; be = -1; m_cnt = 0;
    reset = 1'b0;

    // Reset state with clean inputs
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_pc_en", pc_enable, 1);
    chk("rst_busy", md_busy, 0);
    chk("rst_cnt", stall_cnt, 0);
    step();

    // Load-use: E not ready, then M not ready, then W forward
    rs_addr_D = 1; rs_use_D = 0; dst_addr_E = 1; dst_save_E = 2;
    #1 chk("lw_E_stall", stall, 1);
    step();
    chk("lw_cnt1", stall_cnt, 1);
    dst_addr_E = 0; dst_save_E = 0; dst_addr_M = 1; dst_save_M = 1;
    #1 chk("lw_M_stall", stall, 1);
    step();
    dst_addr_M = 0; dst_save_M = 0; dst_addr_W = 1;
    #1 chk("lw_W_fwd", fwd_rs_D, 3);
    chk("lw_W_nostall", stall, 0);
    step();

    // ALU result forwarded from E, E shadows M
    idle_in();
    rt_addr_D = 2; rt_use_D = 0; dst_addr_E = 2; dst_save_E = 0;
    #1 chk("alu_fwdE", fwd_rt_D, 1);
    step();
    dst_addr_M = 2; dst_save_M = 0;
    #1 chk("alu_fwdE_over_M", fwd_rt_D, 1);
    step();

    // Register zero never matches; unused source never stalls
    idle_in();
    rs_use_D = 0; dst_save_E = 2;
    #1 chk("r0_nostall", stall, 0);
    chk("r0_fwd", fwd_rs_D, 0);
    step();
    rs_addr_D = 5; rs_use_D = 4; dst_addr_E = 5; dst_save_E = 3;
    #1 chk("unused_nostall", stall, 0);
    step();

    // mult then mflo: stall start cycle plus MULT_LAT-1 busy cycles
    for (int k = 0; k < 2; k++) begin
      int lat;
      lat = (k == 0) ? MULT_LAT : DIV_LAT;
      idle_in();
      md_start_E = 1; md_is_div_E = (k == 1); md_use_D = 1;
      busy_seen = 0; done_seen = 0;
      step();
      md_start_E = 0;
      for (int i = 0; i < lat + 1; i++) begin
        #1;
        if (md_busy) busy_seen++;
        if (md_done) done_seen++;
        step();
      end
      chk("md_busy_len", busy_seen, lat - 1);
      chk("md_done_cnt", done_seen, 1);
    end

    // Reset in the middle of a divide
    idle_in();
    md_start_E = 1; md_is_div_E = 1; md_use_D = 1;
    step();
    md_start_E = 0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("midrst_busy", md_busy, 0);
    chk("midrst_cnt", stall_cnt, 0);
    done_seen = 0;
    for (int i = 0; i < DIV_LAT; i++) begin
      #1 if (md_done) done_seen++;
      step();
    end
    chk("midrst_nodone", done_seen, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rs_addr_D   = 5'($urandom_range(0, 3));
      rt_addr_D   = 5'($urandom_range(0, 3));
      rs_use_D    = 4'($urandom_range(0, 4));
      rt_use_D    = 4'($urandom_range(0, 4));
      md_use_D    = ($urandom_range(0, 3) == 0);
      dst_addr_E  = 5'($urandom_range(0, 3));
      dst_save_E  = 4'($urandom_range(0, 3));
      dst_addr_M  = 5'($urandom_range(0, 3));
      dst_save_M  = 4'($urandom_range(0, 2));
      dst_addr_W  = 5'($urandom_range(0, 3));
      md_start_E  = ($urandom_range(0, 7) == 0);
      md_is_div_E = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;
    idle_in();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
